uart_wb_master: RTL and testbench

Wishbone classic single-access initiator that drives the UART register slave from a local command/response port. It turns write, read and poll-until-bit-set commands into bus cycles on the UART's Wishbone slave interface. It returns read data or an error, and optionally bounds each command with a timeout. It sits between a host controller (CPU-less sequencer, test harness or bridge) and the UART register block.

---
 rtl/uart_wb_master.sv | 122 ++++++++++++
 tb/tb_uart_wb_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// uart_wb_master: Wishbone classic initiator turning write/read/poll commands into UART register accesses.
// Define UART_WBM_TIMEOUT_EN to bound each command with a TIMEOUT_CYCLES watchdog.
module uart_wb_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int POLL_GAP = 4
) (
  input  logic                  clk,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i
);
  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  state_t state, state_n;
  logic [1:0] op, op_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] data, data_n;
  logic [DATA_WIDTH-1:0] rsp_data_n;
  logic rsp_err_n;
  logic [7:0] gap_cnt;
  logic accept, hit, expire, gap_done;
  assign accept = cmd_valid_i && state == IDLE;
  assign cmd_ready_o = state == IDLE;
  assign rsp_valid_o = state == RESP;
  assign op_n = accept ? cmd_op_i : op;
  assign addr_n = accept ? cmd_addr_i : addr;
  assign data_n = accept ? cmd_data_i : data;
  assign hit = |(wb_dat_i & data);
  assign gap_done = gap_cnt == 8'(POLL_GAP - 1);
`ifdef UART_WBM_TIMEOUT_EN
  logic [15:0] to_cnt;
  // Expires on the TIMEOUT_CYCLES-th counted cycle; spans every access of a poll.
  assign expire = (state == BUS || state == GAP) && to_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) to_cnt <= '0;
    else to_cnt <= accept ? '0 : (state == BUS || state == GAP) ? to_cnt + 16'd1 : to_cnt;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    rsp_data_n = rsp_data_o;
    rsp_err_n = rsp_err_o;
    case (state)
      IDLE: if (cmd_valid_i) begin
        state_n = cmd_op_i == OP_RSVD ? RESP : BUS;
        rsp_data_n = '0;
        rsp_err_n = cmd_op_i == OP_RSVD;
      end
      BUS: if (wb_ack_i) begin
        if (op == OP_POLL && !hit) state_n = GAP;
        else begin
          state_n = RESP;
          rsp_data_n = op == OP_WRITE ? '0 : wb_dat_i;
          rsp_err_n = 1'b0;
        end
      end else if (expire) begin
        state_n = RESP;
        rsp_data_n = '0;
        rsp_err_n = 1'b1;
      end
      GAP: if (expire) begin
        state_n = RESP;
        rsp_data_n = '0;
        rsp_err_n = 1'b1;
      end else if (gap_done) state_n = BUS;
      RESP: if (rsp_ready_i) begin
        state_n = IDLE;
        rsp_data_n = '0;
        rsp_err_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they are glitch-free and zero outside BUS.
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      data <= '0;
      gap_cnt <= '0;
      rsp_data_o <= '0;
      rsp_err_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_n;
      op <= op_n;
      addr <= addr_n;
      data <= data_n;
      gap_cnt <= state == GAP ? gap_cnt + 8'd1 : '0;
      rsp_data_o <= rsp_data_n;
      rsp_err_o <= rsp_err_n;
      wb_cyc_o <= state_n == BUS;
      wb_stb_o <= state_n == BUS;
      wb_we_o <= state_n == BUS && op_n == OP_WRITE;
      wb_addr_o <= state_n == BUS ? addr_n : '0;
      wb_dat_o <= state_n == BUS && op_n == OP_WRITE ? data_n : '0;
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed self-checking bench for uart_wb_master.
module tb_uart_wb_master;
  logic clk = 1'b0;
  logic wb_rst_ni = 1'b0;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic [1:0] cmd_op_i = '0;
  logic [2:0] cmd_addr_i = '0;
  logic [7:0] cmd_data_i = '0;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b0;
  logic [7:0] rsp_data_o;
  logic rsp_err_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic wb_we_o, wb_stb_o, wb_cyc_o;
  logic wb_ack_i = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_stb = 0;
  int cyc_no = 0;
  logic stb_q = 1'b0;
  always #5 clk = ~clk;
  uart_wb_master #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .POLL_GAP(4)) dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc_no++;
    if (wb_stb_o && !stb_q) n_stb++;
    stb_q = wb_stb_o;
  endtask
  task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] dat);
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_addr_i = addr;
    cmd_data_i = dat;
    step();
    cmd_valid_i = 1'b0;
  endtask
  task automatic handshake(input string tag);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid_o, 0);
    check({tag, "_ready_back"}, cmd_ready_o, 1);
  endtask
  logic [7:0] pv [3];
  int t [3];
  int cnt;
  initial begin
    pv[0] = 8'h00; pv[1] = 8'h00; pv[2] = 8'h20;
    step(); step();
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 0);
    check("rst_ready", cmd_ready_o, 1);
    wb_rst_ni = 1'b1;
    step();
    // write 0x41 to addr 0, ack two cycles after strobe
    issue(2'b00, 3'd0, 8'h41);
    check("wr_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    check("wr_dat", wb_dat_o, 8'h41);
    check("wr_addr", wb_addr_o, 0);
    check("wr_busy", cmd_ready_o, 0);
    step();
    check("wr_hold", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    step();
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    check("wr_release", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check("wr_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h00});
    handshake("wr");
    step();
    // zero-wait read of addr 5
    issue(2'b01, 3'd5, 8'h00);
    check("rd_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o}, {3'b110, 3'd5});
    check("rd_dat_o", wb_dat_o, 0);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h60;
    step();
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    check("rd_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h60});
    check("rd_release", wb_cyc_o, 0);
    handshake("rd");
    step();
    // poll addr 5 mask 0x20: two misses, then hit
    n_stb = 0;
    issue(2'b10, 3'd5, 8'h20);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 20 && !wb_stb_o; w++) step();
      check("poll_stb_seen", wb_stb_o, 1);
      check("poll_we", wb_we_o, 0);
      t[k] = cyc_no;
      wb_ack_i = 1'b1;
      wb_dat_i = pv[k];
      step();
      wb_ack_i = 1'b0;
      wb_dat_i = 8'h00;
      if (k < 2) check("poll_gap_idle", {wb_cyc_o, wb_stb_o, rsp_valid_o}, 0);
    end
    check("poll_gap1", t[1] - t[0], 5);
    check("poll_gap2", t[2] - t[1], 5);
    check("poll_strobes", n_stb, 3);
    check("poll_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h20});
    handshake("poll");
    step();
    // reserved op with a stalled response consumer
    n_stb = 0;
    issue(2'b11, 3'd1, 8'hFF);
    check("rsv_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00});
    repeat (5) step();
    check("rsv_hold", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00});
    check("rsv_busy", cmd_ready_o, 0);
    check("rsv_no_stb", n_stb, 0);
    handshake("rsv");
    step();
    // asynchronous reset in the middle of a bus access
    issue(2'b01, 3'd3, 8'h00);
    check("arst_pre", wb_cyc_o, 1);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("arst_bus", {wb_cyc_o, wb_stb_o}, 0);
    check("arst_rsp", rsp_valid_o, 0);
    step();
    wb_rst_ni = 1'b1;
    step();
    check("arst_ready", cmd_ready_o, 1);
    issue(2'b01, 3'd2, 8'h00);
    check("arst_rd_addr", {wb_stb_o, wb_addr_o}, {1'b1, 3'd2});
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h5A;
    step();
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    check("arst_rd_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h5A});
    handshake("arst");
    step();
`ifdef UART_WBM_TIMEOUT_EN
    // silent slave: bus held for 16 counted cycles, then error
    issue(2'b01, 3'd4, 8'h00);
    cnt = 0;
    while (wb_cyc_o && cnt < 40) begin
      cnt++;
      step();
    end
    check("to_cycles", cnt, 16);
    check("to_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00});
    handshake("to");
    step();
    // ack on the expiry cycle completes normally
    issue(2'b01, 3'd4, 8'h00);
    repeat (15) step();
    check("to_edge_bus", wb_cyc_o, 1);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h33;
    step();
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    check("to_edge_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h33});
    handshake("to_edge");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
